// File: rtl/clap_pattern_detector.sv
// PDM microphone clap detector: mic clock generation, sliding ones-density window,
// hysteretic clap level with refractory period, and multi-clap pattern recognition.
module clap_pattern_detector #(
  parameter int WIN_BITS    = 7,
  parameter int CLK_DIV     = 32,
  parameter int AMP_THR     = 12,
  parameter int AMP_HYST    = 4,
  parameter int REFRACT     = 300_000,
  parameter int PAT_GAP_MAX = 1_500_000,
  parameter int PAT_LEN     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                M_DATA,
  output logic                M_LRSEL,
  output logic                M_CLK,
  output logic [WIN_BITS:0]   amplitude_o,
  output logic                clap_level_o,
  output logic                clap_pulse_o,
  output logic                pattern_pulse_o,
  output logic [3:0]          clap_count_o
);

  localparam int N        = 1 << WIN_BITS;
  localparam int HALF_DIV = CLK_DIV / 2;
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int REF_W    = $clog2(REFRACT + 1);
  localparam int GAP_W    = $clog2(PAT_GAP_MAX + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(HALF_DIV - 1);
  localparam logic [WIN_BITS:0]   AMP_MID    = (WIN_BITS+1)'(N / 2);
  localparam logic [WIN_BITS-1:0] PTR_LAST   = WIN_BITS'(N - 1);
  localparam logic [WIN_BITS-1:0] SET_THR    = WIN_BITS'(AMP_THR);
  localparam logic [WIN_BITS-1:0] CLR_THR    = WIN_BITS'(AMP_THR - AMP_HYST);
  localparam logic [REF_W-1:0]    REF_LOAD   = REF_W'(REFRACT);
  localparam logic [GAP_W-1:0]    GAP_LIMIT  = GAP_W'(PAT_GAP_MAX);
  localparam logic [3:0]          PAT_TARGET = 4'(PAT_LEN);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [DIV_W-1:0]    div_cnt;
  logic                div_wrap;
  logic                s_tick;
  logic                data_s1, data_s;
  logic [N-1:0]        window;
  logic [WIN_BITS-1:0] ptr;
  logic [WIN_BITS:0]   amp;
  logic                warm;
  logic [WIN_BITS-1:0] off, off_nxt;
  logic                off_warm;
  logic                level, level_nxt;
  logic                accept;
  logic [REF_W-1:0]    refract_cnt;
  state_t              state, state_nxt;
  logic [3:0]          count, count_nxt;
  logic [GAP_W-1:0]    gap, gap_nxt;
  logic                pattern_nxt;

  assign M_LRSEL      = 1'b0;
  assign amplitude_o  = amp;
  assign clap_level_o = level;
  assign clap_count_o = count;

  // The sample strobe is the cycle in which M_CLK is about to fall.
  assign div_wrap = (div_cnt == DIV_LAST);
  assign s_tick   = div_wrap & M_CLK;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
      data_s1 <= 1'b0;
      data_s  <= 1'b0;
    end else begin
      data_s1 <= M_DATA;
      data_s  <= data_s1;
      if (div_wrap) begin
        div_cnt <= '0;
        M_CLK   <= ~M_CLK;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // NOTE: the window is a flop array, not RAM, so it is cleared by reset; amp stays its exact popcount.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      window <= '0;
      ptr    <= '0;
      amp    <= '0;
      warm   <= 1'b0;
    end else if (s_tick) begin
      amp         <= amp + (WIN_BITS+1)'(data_s) - (WIN_BITS+1)'(window[ptr]);
      window[ptr] <= data_s;
      ptr         <= ptr + WIN_BITS'(1);
      if (ptr == PTR_LAST) warm <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    off_nxt = '0;
    if (amp >= AMP_MID) off_nxt = WIN_BITS'(amp - AMP_MID);
    else                off_nxt = WIN_BITS'(AMP_MID - amp);
  end

  // off_warm travels with off so the first post-warm-up decision sees a valid offset.
  always_comb begin
    level_nxt = level;
    if (!off_warm)          level_nxt = 1'b0;
    else if (off > SET_THR) level_nxt = 1'b1;
    else if (off < CLR_THR) level_nxt = 1'b0;
  end

  assign accept = level_nxt & ~level & en_i & off_warm & (refract_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      off             <= '0;
      off_warm        <= 1'b0;
      level           <= 1'b0;
      clap_pulse_o    <= 1'b0;
      pattern_pulse_o <= 1'b0;
      refract_cnt     <= '0;
    end else begin
      off             <= off_nxt;
      off_warm        <= warm;
      level           <= level_nxt;
      clap_pulse_o    <= accept;
      pattern_pulse_o <= pattern_nxt;
      if (!en_i)                            refract_cnt <= '0;
      else if (accept)                      refract_cnt <= REF_LOAD;
      else if (s_tick && refract_cnt != '0) refract_cnt <= refract_cnt - REF_W'(1);
    end
  end

  // Pattern FSM: a clap always beats a simultaneous gap timeout.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    gap_nxt     = gap;
    pattern_nxt = 1'b0;
    if (!en_i || !off_warm) begin
      state_nxt = IDLE;
      count_nxt = '0;
      gap_nxt   = '0;
    end else if (accept) begin
      gap_nxt = '0;
      if (count + 4'd1 == PAT_TARGET) begin
        pattern_nxt = 1'b1;
        count_nxt   = '0;
        state_nxt   = IDLE;
      end else begin
        count_nxt = count + 4'd1;
        state_nxt = COUNT;
      end
    end else if (state == COUNT) begin
      if (gap >= GAP_LIMIT) begin
        state_nxt = IDLE;
        count_nxt = '0;
        gap_nxt   = '0;
      end else if (s_tick) begin
        gap_nxt = gap + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
      gap   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      gap   <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_clap_pattern_detector.sv
// Bench for clap_pattern_detector: per-sample reference model over a sample queue with
// timestamp-based refractory/gap rules, scenario table, hand corner cases and random bursts.
module tb_clap_pattern_detector;

  localparam int WIN_BITS    = 4;
  localparam int N           = 16;
  localparam int CLK_DIV     = 4;
  localparam int AMP_THR     = 4;
  localparam int AMP_HYST    = 2;
  localparam int REFRACT     = 20;
  localparam int PAT_GAP_MAX = 100;
  localparam int PAT_LEN     = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              en_i = 1'b0;
  logic              M_DATA = 1'b0;
  logic              M_LRSEL, M_CLK;
  logic [WIN_BITS:0] amplitude_o;
  logic              clap_level_o, clap_pulse_o, pattern_pulse_o;
  logic [3:0]        clap_count_o;

  clap_pattern_detector #(
    .WIN_BITS(WIN_BITS), .CLK_DIV(CLK_DIV), .AMP_THR(AMP_THR), .AMP_HYST(AMP_HYST),
    .REFRACT(REFRACT), .PAT_GAP_MAX(PAT_GAP_MAX), .PAT_LEN(PAT_LEN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .M_DATA(M_DATA),
    .M_LRSEL(M_LRSEL), .M_CLK(M_CLK), .amplitude_o(amplitude_o),
    .clap_level_o(clap_level_o), .clap_pulse_o(clap_pulse_o),
    .pattern_pulse_o(pattern_pulse_o), .clap_count_o(clap_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_claps = 0;
  int dut_pats  = 0;
  int peak_amp  = 0;
  int level_i1  = 0;
  bit alt_ph    = 1'b1;

  // Reference model: last N samples as a queue, claps tracked by sample timestamps.
  bit m_win[$];
  int m_ns, m_cnt, m_last_clap, m_last_acc;
  bit m_level, m_ref_act, exp_clap, exp_pat;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_amp();
    int s = 0;
    foreach (m_win[k]) s += m_win[k];
    return s;
  endfunction

  task automatic model_reset();
    m_win.delete();
    repeat (N) m_win.push_back(1'b0);
    m_ns = 0; m_cnt = 0; m_last_clap = 0; m_last_acc = 0;
    m_level = 0; m_ref_act = 0; exp_clap = 0; exp_pat = 0;
  endtask

  task automatic model_push(input bit b);
    m_win.push_back(b);
    void'(m_win.pop_front());
    m_ns++;
  endtask

  // Decision for the most recent sample, taken with the enable in force while it is evaluated.
  task automatic model_decide(input bit e);
    int off;
    bit lvl, rise;
    off = m_amp() - N / 2;
    if (off < 0) off = -off;
    exp_clap = 0;
    exp_pat  = 0;
    if (m_ns < N)                       lvl = 0;
    else if (off > AMP_THR)             lvl = 1;
    else if (off < AMP_THR - AMP_HYST)  lvl = 0;
    else                                lvl = m_level;
    rise = lvl && !m_level;
    m_level = lvl;
    if (!e) begin
      m_cnt = 0;
      m_ref_act = 0;
    end else if (m_cnt > 0 && m_ns - m_last_clap >= PAT_GAP_MAX) begin
      m_cnt = 0;
    end
    if (rise && e && m_ns >= N && (!m_ref_act || m_ns - m_last_acc >= REFRACT)) begin
      exp_clap    = 1;
      m_ref_act   = 1;
      m_last_acc  = m_ns;
      m_last_clap = m_ns;
      if (m_cnt + 1 == PAT_LEN) begin
        exp_pat = 1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One sample period; entered and left on the falling edge right after a sample edge.
  task automatic do_tick(input bit b, input bit e);
    M_DATA = b;
    en_i   = e;
    for (int i = 0; i < CLK_DIV; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("m_clk", M_CLK, int'(i == 1 || i == 2));
      if (i == 0) model_decide(e);
      if (i == 1) begin
        check("clap_pulse", clap_pulse_o, exp_clap);
        check("pattern_pulse", pattern_pulse_o, exp_pat);
        check("clap_level", clap_level_o, m_level);
        check("clap_count", clap_count_o, m_cnt);
        level_i1 = clap_level_o;
      end else begin
        check("clap_pulse_idle", clap_pulse_o, 0);
        check("pattern_pulse_idle", pattern_pulse_o, 0);
      end
      dut_claps += int'(clap_pulse_o);
      dut_pats  += int'(pattern_pulse_o);
      if (i == CLK_DIV - 1) begin
        model_push(b);
        check("amplitude", amplitude_o, m_amp());
        if (int'(amplitude_o) > peak_amp) peak_amp = int'(amplitude_o);
      end
    end
  endtask

  task automatic quiet(input int n, input bit e);
    repeat (n) begin
      do_tick(alt_ph, e);
      alt_ph = ~alt_ph;
    end
  endtask

  task automatic burst(input bit e);
    repeat (16) do_tick(1'b1, e);
  endtask

  typedef struct {
    int gap;
    bit en;
    int claps;
    int pats;
  } scen_t;

  scen_t scen[4];

  initial begin
    int c0, p0;
    scen[0] = '{gap: 10,  en: 1'b1, claps: 1, pats: 0};
    scen[1] = '{gap: 40,  en: 1'b1, claps: 2, pats: 1};
    scen[2] = '{gap: 150, en: 1'b1, claps: 2, pats: 0};
    scen[3] = '{gap: 40,  en: 1'b0, claps: 0, pats: 0};

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_amplitude", amplitude_o, 0);
    check("rst_m_clk", M_CLK, 0);
    check("rst_lrsel", M_LRSEL, 0);
    check("rst_level", clap_level_o, 0);
    check("rst_count", clap_count_o, 0);
    check("rst_pulses", int'(clap_pulse_o) + int'(pattern_pulse_o), 0);
    rst_i = 1'b1;
    model_reset();

    // Alternating data: density settles mid-scale, no claps
    alt_ph = 1'b1;
    quiet(24, 1'b1);
    check("settled_amp", amplitude_o, 8);
    check("settled_claps", dut_claps, 0);

    // Single burst: one clap, count held then cleared by the gap timeout
    c0 = dut_claps;
    peak_amp = 0;
    burst(1'b1);
    quiet(16, 1'b1);
    check("single_claps", dut_claps - c0, 1);
    check("single_peak", peak_amp, 16);
    check("single_count", clap_count_o, 1);
    quiet(100, 1'b1);
    check("single_timeout_count", clap_count_o, 0);

    // Offset 5 -> 3 -> 5: hysteresis keeps the level, only one clap
    c0 = dut_claps;
    for (int k = 0; k < 40 && m_amp() != 13; k++) do_tick(1'b1, 1'b1);
    for (int k = 0; k < 40 && m_amp() != 11; k++) do_tick(1'b0, 1'b1);
    do_tick(1'b1, 1'b1);
    check("hyst_level_held", level_i1, 1);
    for (int k = 0; k < 40 && m_amp() != 13; k++) do_tick(1'b1, 1'b1);
    quiet(120, 1'b1);
    check("hyst_claps", dut_claps - c0, 1);

    // Two-burst scenarios
    for (int s = 0; s < 4; s++) begin
      c0 = dut_claps;
      p0 = dut_pats;
      burst(scen[s].en);
      quiet(scen[s].gap, scen[s].en);
      burst(scen[s].en);
      quiet(120, scen[s].en);
      check($sformatf("scen%0d_claps", s), dut_claps - c0, scen[s].claps);
      check($sformatf("scen%0d_pats", s), dut_pats - p0, scen[s].pats);
      check($sformatf("scen%0d_count", s), clap_count_o, 0);
    end

    // Random segments against the model
    for (int seg = 0; seg < 30; seg++) begin
      int typ, len;
      bit e;
      typ = $urandom_range(0, 3);
      len = (typ == 0) ? $urandom_range(5, 40) : $urandom_range(4, 16);
      e   = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < len; k++) begin
        case (typ)
          0:       begin do_tick(alt_ph, e); alt_ph = ~alt_ph; end
          1:       do_tick(1'b1, e);
          2:       do_tick(1'b0, e);
          default: do_tick(1'($urandom_range(0, 1)), e);
        endcase
      end
    end
    quiet(120, 1'b1);

    // Asynchronous reset between claps of a pattern
    burst(1'b1);
    quiet(5, 1'b1);
    check("pre_reset_count", clap_count_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("async_amp", amplitude_o, 0);
    check("async_count", clap_count_o, 0);
    check("async_level", clap_level_o, 0);
    check("async_m_clk", M_CLK, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    alt_ph = 1'b1;
    c0 = dut_claps;
    p0 = dut_pats;
    quiet(16, 1'b1);
    burst(1'b1);
    quiet(10, 1'b1);
    check("post_reset_claps", dut_claps - c0, 1);
    check("post_reset_pats", dut_pats - p0, 0);
    check("post_reset_count", clap_count_o, 1);
    check("lrsel", M_LRSEL, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
